calc_sequencer: RTL and testbench



---
 rtl/calc_pkg.sv | 25 ++
 rtl/calc_stack.sv | 38 +++
 rtl/calc_sequencer.sv | 117 +++++++++++
 tb/tb_calc_sequencer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared token codes, ALU opcodes, FSM states and error codes
// for the stack calculator sequencer.
package calc_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_OPER, S_ALU, S_WRITE, S_DONE, S_ERR
   } state_t;
   localparam logic [3:0] TOK_ADD = 4'hA;
   localparam logic [3:0] TOK_SUB = 4'hB;
   localparam logic [3:0] TOK_MUL = 4'hC;
   localparam logic [3:0] TOK_DIV = 4'hD;
   localparam logic [3:0] TOK_EQ  = 4'hE;
   localparam logic [3:0] TOK_ENT = 4'hF;
   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_UNDER   = 2'd1;
   localparam logic [1:0] ERR_OVER    = 2'd2;
   localparam logic [1:0] ERR_ILLEGAL = 2'd3;
   // Operator tokens A..D map onto opcodes 0..3; the low two bits offset by 2 do it.
   function automatic logic [1:0] tok_to_op(input logic [3:0] t);
      return t[1:0] + 2'd2;
   endfunction
endpackage

// File: rtl/calc_stack.sv
// calc_stack: register-array LIFO with single push and double pop.
// Ports: clk, reset (sync, active-high), push, pop2, din -> top, second, depth, full.
// Entry 0 is always the top, so pushes shift down and pop2 shifts up by two.
module calc_stack
   import calc_pkg::*;
#(
   parameter int W = 32,
   parameter int DEPTH = 8,
   localparam int DW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop2,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  top,
   output logic [W-1:0]  second,
   output logic [DW-1:0] depth,
   output logic          full
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (reset) begin
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (pop2) begin
         for (int i = 0; i < DEPTH - 2; i++) mem[i] <= mem[i+2];
         depth <= depth - DW'(2);
      end else if (push) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
         depth <= depth + DW'(1);
      end
   end
   assign top = mem[0];
   assign second = mem[1];
   assign full = depth == DW'(DEPTH);
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: RPN evaluation controller between keypad decoder and a multi-cycle ALU.
// Ports: clk, reset (sync, active-high); token in: tok_valid, tok, tok_ready;
//        ALU handshake: alu_req, alu_op, alu_a, alu_b, alu_ack, alu_result;
//        status: answer, answer_valid, error, err_code, depth.
// Build option: define CALC_SEQ_DIV_EN to let token D issue a divide; otherwise D is illegal.
module calc_sequencer
   import calc_pkg::*;
#(
   parameter int W = 32,
   parameter int DEPTH = 8,
   localparam int DW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tok_valid,
   input  logic [3:0]    tok,
   output logic          tok_ready,
   output logic          alu_req,
   output logic [1:0]    alu_op,
   output logic [W-1:0]  alu_a,
   output logic [W-1:0]  alu_b,
   input  logic          alu_ack,
   input  logic [W-1:0]  alu_result,
   output logic [W-1:0]  answer,
   output logic          answer_valid,
   output logic          error,
   output logic [1:0]    err_code,
   output logic [DW-1:0] depth
);
`ifdef CALC_SEQ_DIV_EN
   localparam logic DIV_EN = 1'b1;
`else
   localparam logic DIV_EN = 1'b0;
`endif
   state_t state;
   logic [3:0] op_q;
   logic [W-1:0] acc, res_q, top, second;
   logic pending, full, push, pop2;
   // Stack controls are decoded from the state so they line up with the FSM's own checks.
   assign push = (state == S_FLUSH && !full) || state == S_WRITE;
   assign pop2 = state == S_OPER && depth >= DW'(2);
   calc_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
      .clk(clk), .reset(reset), .push(push), .pop2(pop2),
      .din(state == S_WRITE ? res_q : acc),
      .top(top), .second(second), .depth(depth), .full(full)
   );
   assign tok_ready = state == S_IDLE;
   assign alu_req = state == S_ALU;
   assign answer_valid = state == S_DONE;
   assign error = state == S_ERR;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         op_q <= '0;
         acc <= '0;
         pending <= 1'b0;
         res_q <= '0;
         alu_op <= OP_ADD;
         alu_a <= '0;
         alu_b <= '0;
         answer <= '0;
         err_code <= ERR_NONE;
      end else begin
         case (state)
            S_IDLE: if (tok_valid) begin
               if (tok <= 4'd9) begin
                  acc <= acc * W'(10) + W'(tok);
                  pending <= 1'b1;
               end else begin
                  op_q <= tok;
                  if (tok == TOK_DIV && !DIV_EN) begin
                     state <= S_ERR;
                     err_code <= ERR_ILLEGAL;
                  end else if (pending) begin
                     state <= S_FLUSH;
                  end else if (tok == TOK_EQ) begin
                     if (depth == '0) begin
                        state <= S_ERR;
                        err_code <= ERR_UNDER;
                     end else begin
                        answer <= top;
                        state <= S_DONE;
                     end
                  end else if (tok != TOK_ENT) begin
                     state <= S_OPER;
                  end
               end
            end
            S_FLUSH: if (full) begin
               state <= S_ERR;
               err_code <= ERR_OVER;
            end else begin
               // The pushed value becomes the top, so an equal resolves to acc itself.
               acc <= '0;
               pending <= 1'b0;
               if (op_q == TOK_EQ) answer <= acc;
               state <= op_q == TOK_ENT ? S_IDLE : op_q == TOK_EQ ? S_DONE : S_OPER;
            end
            S_OPER: if (depth < DW'(2)) begin
               state <= S_ERR;
               err_code <= ERR_UNDER;
            end else begin
               alu_a <= second;
               alu_b <= top;
               alu_op <= tok_to_op(op_q);
               state <= S_ALU;
            end
            S_ALU: if (alu_ack) begin
               res_q <= alu_result;
               state <= S_WRITE;
            end
            S_WRITE: state <= S_IDLE;
            default: state <= state;
         endcase
      end
   end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: randomized self-checking bench for calc_sequencer against a queue-based RPN model.
module tb_calc_sequencer;
   localparam int W = 32;
   localparam int DEPTH = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tok_valid = 1'b0;
   logic [3:0] tok = '0;
   logic alu_ack = 1'b0;
   logic [W-1:0] alu_result = '0;
   logic tok_ready, alu_req, answer_valid, error;
   logic [1:0] alu_op, err_code;
   logic [W-1:0] alu_a, alu_b, answer;
   logic [3:0] depth;
   int n_asrt = 0;
   int n_fail = 0;
   int alu_lat = 1;
   int req_cyc = 0;
   int req_total = 0;
   bit stray = 0;
   bit got_req = 0;
   bit prev_req = 0;
   logic [W-1:0] first_a, first_b, pa, pb;
   logic [1:0] first_op, pop;
   logic [W-1:0] m_stack [$];
   logic [W-1:0] m_acc, m_ans;
   bit m_pend;
   int m_st;
   int m_code;

   calc_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .tok_valid(tok_valid), .tok(tok), .tok_ready(tok_ready),
      .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ack(alu_ack), .alu_result(alu_result), .answer(answer),
      .answer_valid(answer_valid), .error(error), .err_code(err_code), .depth(depth)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         2'd0: return a + b;
         2'd1: return a - b;
         2'd2: return a * b;
         default: return (b == '0) ? '1 : a / b;
      endcase
   endfunction

   task automatic m_clear();
      m_stack.delete();
      m_acc = '0;
      m_ans = '0;
      m_pend = 0;
      m_st = 0;
      m_code = 0;
   endtask

   // Model: m_st 0 = accepting tokens, 1 = answer produced, 2 = error.
   task automatic m_tok(input logic [3:0] t);
      logic [W-1:0] a, b;
      logic [3:0] d;
      if (m_st != 0) return;
      if (t <= 4'd9) begin
         m_acc = m_acc * 10 + W'(t);
         m_pend = 1;
         return;
      end
`ifndef CALC_SEQ_DIV_EN
      if (t == 4'hD) begin
         m_st = 2;
         m_code = 3;
         return;
      end
`endif
      if (m_pend) begin
         if (m_stack.size() == DEPTH) begin
            m_st = 2;
            m_code = 2;
            return;
         end
         m_stack.push_front(m_acc);
         m_acc = '0;
         m_pend = 0;
      end
      if (t == 4'hF) return;
      if (t == 4'hE) begin
         if (m_stack.size() == 0) begin
            m_st = 2;
            m_code = 1;
         end else begin
            m_st = 1;
            m_ans = m_stack[0];
         end
         return;
      end
      if (m_stack.size() < 2) begin
         m_st = 2;
         m_code = 1;
         return;
      end
      b = m_stack.pop_front();
      a = m_stack.pop_front();
      d = t - 4'hA;
      m_stack.push_front(alu_fn(d[1:0], a, b));
   endtask

   // ALU model: acknowledges after alu_lat request cycles; optionally fires stray acks when idle.
   initial begin
      forever begin
         @(negedge clk);
         alu_ack = 1'b0;
         if (alu_req && !reset) begin
            req_cyc++;
            if (req_cyc >= alu_lat) begin
               alu_ack = 1'b1;
               alu_result = alu_fn(alu_op, alu_a, alu_b);
               req_cyc = 0;
            end
         end else begin
            req_cyc = 0;
            alu_ack = stray && ($urandom_range(0, 1) == 1);
            alu_result = $urandom;
         end
      end
   end

   // Request monitor: operands must stay stable for the whole request.
   always @(negedge clk) begin
      if (reset) begin
         prev_req = 0;
         got_req = 0;
         req_total = 0;
      end else begin
         if (alu_req) begin
            req_total++;
            if (!got_req) begin
               first_a = alu_a;
               first_b = alu_b;
               first_op = alu_op;
               got_req = 1;
            end
            if (prev_req) begin
               n_asrt++;
               if ({alu_a, alu_b, alu_op} !== {pa, pb, pop}) begin
                  n_fail++;
                  $display("FAIL alu_hold: got a=%0d b=%0d op=%0d want a=%0d b=%0d op=%0d", alu_a, alu_b, alu_op, pa, pb, pop);
               end
            end
            pa = alu_a;
            pb = alu_b;
            pop = alu_op;
         end
         prev_req = alu_req;
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      tok_valid = 1'b0;
      alu_lat = 1;
      stray = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_clear();
   endtask

   task automatic settle(input string name);
      int k = 0;
      while (k < 300 && !(m_st == 0 ? tok_ready === 1'b1 : (answer_valid === 1'b1 || error === 1'b1))) begin
         @(negedge clk);
         k++;
      end
      n_asrt++;
      if (k >= 300) begin
         n_fail++;
         $display("FAIL %s timeout: tok_ready=%b answer_valid=%b error=%b model_state=%0d", name, tok_ready, answer_valid, error, m_st);
      end
   endtask

   task automatic send(input logic [3:0] t);
      settle("send_wait");
      tok = t;
      tok_valid = 1'b1;
      @(negedge clk);
      tok_valid = 1'b0;
      m_tok(t);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_asrt++;
      if ({tok_ready, alu_req, answer_valid, error} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/req/val/err=%b want 1000", {tok_ready, alu_req, answer_valid, error});
      end
      n_asrt++;
      if ({alu_op, alu_a, alu_b} !== '0) begin
         n_fail++;
         $display("FAIL reset_alu: got op=%0d a=%0d b=%0d want 0", alu_op, alu_a, alu_b);
      end
      n_asrt++;
      if ({answer, err_code, depth} !== '0) begin
         n_fail++;
         $display("FAIL reset_status: got answer=%0d err_code=%0d depth=%0d want 0", answer, err_code, depth);
      end
      reset = 1'b0;
      m_clear();
   endtask

   task automatic test_basic();
      logic [3:0] seq [7] = '{4'h1, 4'h2, 4'hF, 4'h3, 4'h4, 4'hA, 4'hE};
      do_reset();
      foreach (seq[i]) send(seq[i]);
      settle("basic");
      n_asrt++;
      if ({first_a, first_b, first_op} !== {32'd12, 32'd34, 2'd0}) begin
         n_fail++;
         $display("FAIL basic_operands: got a=%0d b=%0d op=%0d want a=12 b=34 op=0", first_a, first_b, first_op);
      end
      n_asrt++;
      if (answer !== 32'd46 || answer !== m_ans || answer_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_answer: got %0d valid=%b want %0d valid=1", answer, answer_valid, m_ans);
      end
      n_asrt++;
      if (depth !== 4'd1 || tok_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_depth: got depth=%0d rdy=%b want depth=1 rdy=0", depth, tok_ready);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      send(4'h7);
      send(4'hA);
      settle("underflow");
      n_asrt++;
      if ({error, err_code, tok_ready} !== {1'b1, 2'd1, 1'b0} || m_code != 1) begin
         n_fail++;
         $display("FAIL underflow: got err=%b code=%0d rdy=%b want err=1 code=%0d rdy=0", error, err_code, tok_ready, m_code);
      end
      n_asrt++;
      if (req_total != 0) begin
         n_fail++;
         $display("FAIL underflow_req: got %0d request cycles want 0", req_total);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int p = 1; p <= 9; p++) begin
         send(4'h1);
         send(4'hF);
         if (p == 8) begin
            settle("overflow_fill");
            n_asrt++;
            if (depth !== 4'd8) begin
               n_fail++;
               $display("FAIL overflow_full_depth: got %0d want 8", depth);
            end
         end
      end
      settle("overflow");
      n_asrt++;
      if ({error, err_code} !== {1'b1, 2'd2} || m_code != 2) begin
         n_fail++;
         $display("FAIL overflow: got err=%b code=%0d want err=1 code=2", error, err_code);
      end
   endtask

   task automatic test_slow_alu();
      int k = 0;
      do_reset();
      alu_lat = 5;
      send(4'h9);
      send(4'hF);
      send(4'h3);
      send(4'hC);
      while (k < 20 && alu_req !== 1'b1) begin
         @(negedge clk);
         k++;
      end
      // Tokens offered while busy must be dropped.
      for (int i = 0; i < 3; i++) begin
         n_asrt++;
         if (tok_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL slow_busy_ready: got %b want 0 at cycle %0d", tok_ready, i);
         end
         tok = 4'h5;
         tok_valid = 1'b1;
         @(negedge clk);
      end
      tok_valid = 1'b0;
      settle("slow_alu");
      n_asrt++;
      if (req_total != 5) begin
         n_fail++;
         $display("FAIL slow_req_cycles: got %0d want 5", req_total);
      end
      send(4'hE);
      settle("slow_eval");
      n_asrt++;
      if (answer !== 32'd27 || answer !== m_ans || answer_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL slow_answer: got %0d valid=%b want 27", answer, answer_valid);
      end
   endtask

   task automatic test_div();
      do_reset();
      send(4'h8);
      send(4'hF);
      send(4'h2);
      send(4'hD);
      settle("div");
`ifdef CALC_SEQ_DIV_EN
      n_asrt++;
      if (first_op !== 2'd3) begin
         n_fail++;
         $display("FAIL div_op: got %0d want 3", first_op);
      end
      send(4'hE);
      settle("div_eval");
      n_asrt++;
      if (answer !== 32'd4 || answer !== m_ans) begin
         n_fail++;
         $display("FAIL div_answer: got %0d want 4", answer);
      end
`else
      n_asrt++;
      if ({error, err_code} !== {1'b1, 2'd3} || m_code != 3) begin
         n_fail++;
         $display("FAIL div_illegal: got err=%b code=%0d want err=1 code=3", error, err_code);
      end
      n_asrt++;
      if (depth !== 4'd1 || req_total != 0) begin
         n_fail++;
         $display("FAIL div_noflush: got depth=%0d req=%0d want depth=1 req=0", depth, req_total);
      end
`endif
   endtask

   task automatic test_reset_in_alu();
      logic [3:0] wrap [10] = '{4'h4, 4'h2, 4'h9, 4'h4, 4'h9, 4'h6, 4'h7, 4'h2, 4'h9, 4'h6};
      int k = 0;
      do_reset();
      alu_lat = 1000;
      send(4'h5);
      send(4'hF);
      send(4'h6);
      send(4'hA);
      while (k < 20 && alu_req !== 1'b1) begin
         @(negedge clk);
         k++;
      end
      n_asrt++;
      if (alu_req !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_reach_alu: got req=%b want 1", alu_req);
      end
      reset = 1'b1;
      @(negedge clk);
      n_asrt++;
      if ({alu_req, depth, tok_ready} !== {1'b0, 4'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL abort_reset: got req=%b depth=%0d rdy=%b want req=0 depth=0 rdy=1", alu_req, depth, tok_ready);
      end
      reset = 1'b0;
      alu_lat = 1;
      m_clear();
      foreach (wrap[i]) send(wrap[i]);
      send(4'hE);
      settle("wrap");
      n_asrt++;
      if (answer !== 32'd0 || answer !== m_ans || answer_valid !== 1'b1 || depth !== 4'd1) begin
         n_fail++;
         $display("FAIL wrap_answer: got %0d valid=%b depth=%0d want 0 valid=1 depth=1", answer, answer_valid, depth);
      end
   endtask

   task automatic test_random();
      logic [3:0] ops [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      for (int it = 0; it < 25; it++) begin
         int n;
         do_reset();
         alu_lat = $urandom_range(1, 4);
         stray = 1;
         n = $urandom_range(3, 16);
         for (int i = 0; i < n && m_st == 0; i++) begin
            int r = $urandom_range(0, 9);
            if (r < 5) send(4'($urandom_range(0, 9)));
            else if (r < 8) send(ops[$urandom_range(0, 2)]);
            else if (r < 9) send(4'hF);
            else send(ops[$urandom_range(3, 4)]);
         end
         if (m_st == 0) send(4'hE);
         settle("random");
         n_asrt++;
         if (answer_valid !== (m_st == 1) || error !== (m_st == 2) || err_code !== 2'(m_code)) begin
            n_fail++;
            $display("FAIL random_status it=%0d: got val=%b err=%b code=%0d want model_state=%0d code=%0d", it, answer_valid, error, err_code, m_st, m_code);
         end
         n_asrt++;
         if (depth !== 4'(m_stack.size()) || (m_st == 1 && answer !== m_ans)) begin
            n_fail++;
            $display("FAIL random_result it=%0d: got depth=%0d answer=%0d want depth=%0d answer=%0d", it, depth, answer, m_stack.size(), m_ans);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_overflow();
      test_slow_alu();
      test_div();
      test_reset_in_alu();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
